// File: rtl/posit_denormalize_pipe_if.sv
// Stream bundle for the posit decoder: an input posit side and a decoded-field output side.
interface posit_denormalize_pipe_if #(
  parameter int POSIT_WIDTH = 32,
  parameter int POSIT_ES    = 2,
  parameter int NUM_LANES   = 1
);
  localparam int FRAC_W  = POSIT_WIDTH - POSIT_ES - 3;
  localparam int SCALE_W = $clog2((2**POSIT_ES) * (POSIT_WIDTH - 1)) + 1;

  logic                             s_valid;
  logic                             s_ready;
  logic [NUM_LANES*POSIT_WIDTH-1:0] s_posit;
  logic                             m_valid;
  logic                             m_ready;
  logic [NUM_LANES-1:0]             m_sign;
  logic [NUM_LANES-1:0]             m_nar;
  logic [NUM_LANES-1:0]             m_zero;
  logic [NUM_LANES*SCALE_W-1:0]     m_scale;
  logic [NUM_LANES*FRAC_W-1:0]      m_fraction;
  logic [NUM_LANES-1:0]             m_guard;
  logic [NUM_LANES-1:0]             m_round;
  logic [NUM_LANES-1:0]             m_sticky;

  modport master (
    output s_valid, s_posit, m_ready,
    input  s_ready, m_valid, m_sign, m_nar, m_zero, m_scale, m_fraction,
           m_guard, m_round, m_sticky
  );

  modport slave (
    input  s_valid, s_posit, m_ready,
    output s_ready, m_valid, m_sign, m_nar, m_zero, m_scale, m_fraction,
           m_guard, m_round, m_sticky
  );
endinterface

// File: rtl/posit_denormalize_pipe.sv
// Two-stage posit decoder: stage 1 captures sign/specials/magnitude/regime run,
// stage 2 produces scale and left-aligned fraction. Lanes share one handshake.
module posit_denormalize_pipe #(
  parameter int POSIT_WIDTH = 32,
  parameter int POSIT_ES    = 2,
  parameter int NUM_LANES   = 1
) (
  input logic                   clk,
  input logic                   rst,
  posit_denormalize_pipe_if.slave bus
);
  localparam int N       = POSIT_WIDTH;
  localparam int ES      = POSIT_ES;
  localparam int L       = NUM_LANES;
  localparam int FRAC_W  = N - ES - 3;
  localparam int SCALE_W = $clog2((2**ES) * (N - 1)) + 1;
  localparam int RW      = $clog2(N);

  logic               v1, v2, adv2;
  logic [L-1:0]       sign1_d, nar1_d, zero1_d;
  logic [L-1:0]       sign1, nar1, zero1;
  logic [L-1:0]       sign2, nar2, zero2;
  logic [N-2:0]       u1_d [L];
  logic [N-2:0]       u1 [L];
  logic [RW-1:0]      r1_d [L];
  logic [RW-1:0]      r1 [L];
  logic [SCALE_W-1:0] scale2_d [L];
  logic [SCALE_W-1:0] scale2 [L];
  logic [FRAC_W-1:0]  frac2_d [L];
  logic [FRAC_W-1:0]  frac2 [L];

  assign adv2        = ~v2 | bus.m_ready;
  assign bus.s_ready = ~rst & (~v1 | adv2);

  logic [N-1:0] p;
  logic [N-2:0] u;
  logic         run;

  always_comb begin
    p       = '0;
    u       = '0;
    run     = 1'b0;
    sign1_d = '0;
    nar1_d  = '0;
    zero1_d = '0;
    u1_d    = '{default: '0};
    r1_d    = '{default: '0};
    for (int i = 0; i < L; i++) begin
      p          = bus.s_posit[i*N +: N];
      sign1_d[i] = p[N-1];
      nar1_d[i]  = (p == {1'b1, {(N-1){1'b0}}});
      zero1_d[i] = (p == '0);
      u          = p[N-1] ? -p[N-2:0] : p[N-2:0];
      u1_d[i]    = u;
      run        = 1'b1;
      for (int j = N - 2; j >= 0; j--) begin
        run = run & (u[j] == u[N-2]);
        if (run) r1_d[i] = r1_d[i] + RW'(1);
      end
    end
  end

  logic [N-2:0]         rem;
  logic [SCALE_W-1:0]   k, r_ext;
  logic [SCALE_W+N-2:0] wide;

  // {k, rem} sliced at the exponent boundary yields k*2^ES + e without a separate add.
  always_comb begin
    rem      = '0;
    k        = '0;
    r_ext    = '0;
    wide     = '0;
    scale2_d = '{default: '0};
    frac2_d  = '{default: '0};
    for (int i = 0; i < L; i++) begin
      r_ext = SCALE_W'(r1[i]);
      k     = u1[i][N-2] ? (r_ext - SCALE_W'(1)) : (SCALE_W'(0) - r_ext);
      rem   = u1[i] << r1[i];
      rem   = rem << 1;
      wide  = {k, rem};
      if (!(nar1[i] | zero1[i])) begin
        scale2_d[i] = wide[SCALE_W+N-2-ES : N-1-ES];
        frac2_d[i]  = rem[N-ES-2 : 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      sign1  <= '0;
      nar1   <= '0;
      zero1  <= '0;
      u1     <= '{default: '0};
      r1     <= '{default: '0};
      sign2  <= '0;
      nar2   <= '0;
      zero2  <= '0;
      scale2 <= '{default: '0};
      frac2  <= '{default: '0};
    end else begin
      if (bus.s_ready) begin
        v1 <= bus.s_valid;
        if (bus.s_valid) begin
          sign1 <= sign1_d;
          nar1  <= nar1_d;
          zero1 <= zero1_d;
          u1    <= u1_d;
          r1    <= r1_d;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          sign2  <= sign1;
          nar2   <= nar1;
          zero2  <= zero1;
          scale2 <= scale2_d;
          frac2  <= frac2_d;
        end
      end
    end
  end

  assign bus.m_valid  = v2;
  assign bus.m_sign   = sign2;
  assign bus.m_nar    = nar2;
  assign bus.m_zero   = zero2;
  assign bus.m_guard  = '0;
  assign bus.m_round  = '0;
  assign bus.m_sticky = '0;

  always_comb begin
    bus.m_scale    = '0;
    bus.m_fraction = '0;
    for (int i = 0; i < L; i++) begin
      bus.m_scale[i*SCALE_W +: SCALE_W]  = scale2[i];
      bus.m_fraction[i*FRAC_W +: FRAC_W] = frac2[i];
    end
  end
endmodule

// File: tb/tb_posit_denormalize_pipe.sv
// Bench for posit_denormalize_pipe: directed vector table, hand-written stall/reset
// sequences, and a randomized stream compared against a bit-walking reference decoder.
module tb_posit_denormalize_pipe;
  localparam int N  = 32;
  localparam int ES = 2;
  localparam int L  = 4;
  localparam int FW = 27;
  localparam int SW = 8;
  localparam int NT = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_denormalize_pipe_if #(.POSIT_WIDTH(N), .POSIT_ES(ES), .NUM_LANES(L)) bus ();

  posit_denormalize_pipe #(.POSIT_WIDTH(N), .POSIT_ES(ES), .NUM_LANES(L)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] p;
    logic        sign;
    logic        nar;
    logic        zero;
    logic [7:0]  scale;
    logic [26:0] frac;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] lane_got(input int l);
    return {bus.m_sign[l], bus.m_nar[l], bus.m_zero[l],
            bus.m_scale[l*SW +: SW], bus.m_fraction[l*FW +: FW]};
  endfunction

  function automatic logic [159:0] snapshot();
    return 160'({bus.m_valid, bus.m_sign, bus.m_nar, bus.m_zero, bus.m_scale, bus.m_fraction});
  endfunction

  // Walks the bit string left to right, the way posits are defined on paper.
  function automatic logic [37:0] ref_dec(input logic [31:0] p);
    logic [31:0] v;
    logic [26:0] fr;
    logic        rb;
    int          pos, r, k, e;
    fr = '0;
    if (p == 32'h0) return {1'b0, 1'b0, 1'b1, 8'h00, 27'h0};
    if (p == 32'h8000_0000) return {1'b1, 1'b1, 1'b0, 8'h00, 27'h0};
    v   = p[31] ? (~p + 32'd1) : p;
    pos = 30;
    rb  = v[30];
    r   = 0;
    while (pos >= 0 && v[pos] == rb) begin
      r++;
      pos--;
    end
    k = rb ? r - 1 : -r;
    pos--;
    e = 0;
    for (int b = 0; b < 2; b++) begin
      e = e * 2 + ((pos >= 0) ? int'(v[pos]) : 0);
      pos--;
    end
    for (int b = 26; b >= 0; b--) begin
      fr[b] = (pos >= 0) ? v[pos] : 1'b0;
      pos--;
    end
    return {p[31], 1'b0, 1'b0, 8'(k * 4 + e), fr};
  endfunction

  function automatic logic [31:0] rand_posit();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [127:0] table_word(input int t);
    logic [127:0] w;
    w = '0;
    for (int l = 0; l < L; l++) w[l*N +: N] = tbl[(t + l) % 12].p;
    return w;
  endfunction

  logic [127:0] exp_q [$];
  logic [127:0] word_a, word_b, word_c, w;
  logic [159:0] prev_snap;
  logic         prev_stall, seen_valid;
  int           sent, recv, cyc;

  initial begin
    tbl[0]  = '{32'h4000_0000, 1'b0, 1'b0, 1'b0, 8'h00, 27'h0};
    tbl[1]  = '{32'h4800_0000, 1'b0, 1'b0, 1'b0, 8'h01, 27'h0};
    tbl[2]  = '{32'hC000_0000, 1'b1, 1'b0, 1'b0, 8'h00, 27'h0};
    tbl[3]  = '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 8'h78, 27'h0};
    tbl[4]  = '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'h88, 27'h0};
    tbl[5]  = '{32'h8000_0000, 1'b1, 1'b1, 1'b0, 8'h00, 27'h0};
    tbl[6]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 8'h00, 27'h0};
    tbl[7]  = '{32'h5000_0000, 1'b0, 1'b0, 1'b0, 8'h02, 27'h0};
    tbl[8]  = '{32'h4400_0000, 1'b0, 1'b0, 1'b0, 8'h00, 27'h400_0000};
    tbl[9]  = '{32'h3000_0000, 1'b0, 1'b0, 1'b0, 8'hFE, 27'h0};
    tbl[10] = '{32'hB000_0000, 1'b1, 1'b0, 1'b0, 8'h02, 27'h0};
    tbl[11] = '{32'h4A00_0000, 1'b0, 1'b0, 1'b0, 8'h01, 27'h200_0000};

    bus.s_valid = 1'b0;
    bus.s_posit = '0;
    bus.m_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_s_ready", 160'(bus.s_ready), 160'(0));
    chk("rst_m_valid", 160'(bus.m_valid), 160'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", 160'(bus.s_ready), 160'(1));
    chk("post_rst_outputs", snapshot(), 160'(0));

    // Directed table, one transfer at a time, lanes rotated through the table
    for (int t = 0; t < 12; t++) begin
      bus.s_valid = 1'b1;
      bus.s_posit = table_word(t);
      #1;
      chk("dir_s_ready", 160'(bus.s_ready), 160'(1));
      tick();
      bus.s_valid = 1'b0;
      chk("dir_lat1", 160'(bus.m_valid), 160'(0));
      tick();
      chk("dir_lat2", 160'(bus.m_valid), 160'(1));
      for (int l = 0; l < L; l++)
        chk($sformatf("dir_t%0d_l%0d", t, l), 160'(lane_got(l)),
            160'({tbl[(t+l)%12].sign, tbl[(t+l)%12].nar, tbl[(t+l)%12].zero,
                  tbl[(t+l)%12].scale, tbl[(t+l)%12].frac}));
      chk("dir_grs", 160'({bus.m_guard, bus.m_round, bus.m_sticky}), 160'(0));
    end
    tick();
    chk("dir_drain", 160'(bus.m_valid), 160'(0));

    // Backpressure: fill, stall, then simultaneous accept and emit
    word_a = table_word(1);
    word_b = table_word(3);
    word_c = table_word(8);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_posit = word_a;
    tick();
    bus.s_posit = word_b;
    #1;
    chk("bp_ready_half", 160'(bus.s_ready), 160'(1));
    tick();
    bus.s_posit = word_c;
    #1;
    chk("bp_ready_full", 160'(bus.s_ready), 160'(0));
    tick();
    chk("bp_hold_a", 160'({bus.m_valid, lane_got(0)}), 160'({1'b1, ref_dec(word_a[31:0])}));
    bus.m_ready = 1'b1;
    #1;
    chk("bp_ready_emit", 160'(bus.s_ready), 160'(1));
    tick();
    bus.s_valid = 1'b0;
    chk("bp_b", 160'({bus.m_valid, lane_got(0)}), 160'({1'b1, ref_dec(word_b[31:0])}));
    tick();
    chk("bp_c", 160'({bus.m_valid, lane_got(2)}), 160'({1'b1, ref_dec(word_c[95:64])}));
    tick();
    chk("bp_empty", 160'(bus.m_valid), 160'(0));

    // Reset with two transfers in flight
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_posit = table_word(4);
    tick();
    bus.s_posit = table_word(9);
    tick();
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_s_ready", 160'(bus.s_ready), 160'(0));
    tick();
    chk("mid_rst_m_valid", 160'(bus.m_valid), 160'(0));
    chk("mid_rst_outputs", snapshot(), 160'(0));
    rst = 1'b0;
    bus.m_ready = 1'b1;
    #1;
    chk("mid_rst_ready_after", 160'(bus.s_ready), 160'(1));
    seen_valid = 1'b0;
    repeat (5) begin
      tick();
      seen_valid = seen_valid | bus.m_valid;
    end
    chk("mid_rst_no_stale", 160'(seen_valid), 160'(0));

    // Random stream against the reference decoder
    sent = 0;
    recv = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_snap = '0;
    while (recv < NT && cyc < 60000) begin
      @(posedge clk);
      #1;
      if (prev_stall) chk("stall_stable", snapshot(), prev_snap);
      bus.s_valid = (sent < NT) && ($urandom_range(0, 3) != 0);
      for (int l = 0; l < L; l++) bus.s_posit[l*N +: N] = rand_posit();
      bus.m_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(bus.s_posit);
        sent++;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", 160'(1), 160'(0));
        end else begin
          w = exp_q.pop_front();
          chk("stream_data",
              160'({lane_got(3), lane_got(2), lane_got(1), lane_got(0),
                    bus.m_guard, bus.m_round, bus.m_sticky}),
              160'({ref_dec(w[127:96]), ref_dec(w[95:64]), ref_dec(w[63:32]),
                    ref_dec(w[31:0]), 12'h000}));
        end
        recv++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_snap = snapshot();
      cyc++;
    end
    bus.s_valid = 1'b0;
    chk("stream_count", 160'(recv), 160'(NT));
    chk("stream_queue_empty", 160'(exp_q.size()), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
